// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the APB master arbiter.
//  - state_t        : transfer sequencer states
//  - SLV_*          : slave index map inside the peripheral region
//  - SLAVE_SIZE     : byte size of one slave window (4KB)
//  - SLAVE_ADDR_LSB : lowest address bit of the slave index field
//  - idx_width()    : index width for a vector of n entries (minimum 1 bit)
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int SLV_GPI   = 0;
  localparam int SLV_GPO   = 1;
  localparam int SLV_UART  = 2;
  localparam int SLV_TIMER = 3;

  localparam logic [31:0] SLAVE_SIZE     = 32'h0000_1000;
  localparam int          SLAVE_ADDR_LSB = 12;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping around the request vector.
// Ports:
//  req   in  N   request vector
//  ptr   in  IW  index with highest priority this cycle
//  grant out N   one-hot grant (all zero when no request)
//  idx   out IW  index of the granted request (ptr when none)
//  any   out 1   at least one request asserted
module rr_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // (base + off) mod N, used to walk the request vector starting at ptr.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IW'(sum % $unsigned(N));
  endfunction

  // rot[k] is the request sitting k positions after the pointer.
  logic [N-1:0] rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot[gi] = req[wrap_add(ptr, gi)];
  end

  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        idx = wrap_add(ptr, k);
      end
    end
  end

  assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by N_REQ requesters. Round-robin grants one request at
// a time, decodes it to one of N_SLV 4KB slave windows above BASE_ADDR,
// runs the APB SETUP/ACCESS sequence and returns a one-cycle response to
// the owner. Out-of-region addresses and slaves that stay busy for TIMEOUT
// ACCESS cycles complete with rsp_err.
// Ports:
//  PCLK, PRESET             clock, synchronous active-high reset
//  req_valid/write/addr/wdata per-requester request
//  req_ready                one-cycle grant pulse per requester
//  rsp_valid                one-cycle completion pulse to the owner
//  rsp_rdata, rsp_err       completion payload, valid with rsp_valid
//  PADDR/PWRITE/PWDATA      latched APB address, direction, write data
//  PENABLE, PSEL            APB access phase and one-hot slave select
//  PRDATA_s, PREADY_s       per-slave read data and ready
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter int          N_SLV     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [N_REQ-1:0][31:0] req_addr,
  input  logic [N_REQ-1:0][31:0] req_wdata,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [N_SLV-1:0]       PSEL,
  input  logic [N_SLV-1:0][31:0] PRDATA_s,
  input  logic [N_SLV-1:0]       PREADY_s
);

  localparam int          RW          = idx_width(N_REQ);
  localparam int          SW          = idx_width(N_SLV);
  localparam int          CW          = $clog2(TIMEOUT + 1);
  localparam logic [31:0] REGION_SIZE = 32'(N_SLV) * SLAVE_SIZE;

  state_t         state_reg, state_next;
  logic [RW-1:0]  ptr_reg, ptr_next;
  logic [RW-1:0]  owner_reg, owner_next;
  logic [31:0]    paddr_reg, paddr_next;
  logic           pwrite_reg, pwrite_next;
  logic [31:0]    pwdata_reg, pwdata_next;
  logic [SW-1:0]  slv_reg, slv_next;
  logic           hit_reg, hit_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [31:0]    rdata_reg, rdata_next;
  logic           err_reg, err_next;

  logic [N_REQ-1:0] arb_grant;
  logic [RW-1:0]    arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (RW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Address decode of the winning request. The slave index is taken from
  // the region offset, which equals addr[12 +: SW] for an aligned base.
  logic [31:0]   win_addr;
  logic [31:0]   dec_offset;
  logic          dec_hit;
  logic [SW-1:0] dec_idx;

  assign win_addr   = req_addr[arb_idx];
  assign dec_offset = win_addr - BASE_ADDR;
  assign dec_hit    = (win_addr >= BASE_ADDR) && (dec_offset < REGION_SIZE);
  assign dec_idx    = dec_offset[SLAVE_ADDR_LSB +: SW];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      owner_reg  <= '0;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      slv_reg    <= '0;
      hit_reg    <= 1'b0;
      cnt_reg    <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      owner_reg  <= owner_next;
      paddr_reg  <= paddr_next;
      pwrite_reg <= pwrite_next;
      pwdata_reg <= pwdata_next;
      slv_reg    <= slv_next;
      hit_reg    <= hit_next;
      cnt_reg    <= cnt_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    owner_next  = owner_reg;
    paddr_next  = paddr_reg;
    pwrite_next = pwrite_reg;
    pwdata_next = pwdata_reg;
    slv_next    = slv_reg;
    hit_next    = hit_reg;
    cnt_next    = cnt_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;

    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    PSEL      = '0;
    PENABLE   = 1'b0;

    case (state_reg)
      IDLE: begin
        // No grant while reset is held so a request is never lost.
        if (arb_any && !PRESET) begin
          req_ready   = arb_grant;
          owner_next  = arb_idx;
          paddr_next  = win_addr;
          pwrite_next = req_write[arb_idx];
          pwdata_next = req_wdata[arb_idx];
          hit_next    = dec_hit;
          slv_next    = dec_idx;
          rdata_next  = '0;
          err_next    = 1'b0;
          ptr_next    = (arb_idx == RW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        // A decode miss spends this cycle with no PSEL and then reports the
        // error, so misses respond two cycles after the grant.
        if (hit_reg) begin
          PSEL[slv_reg] = 1'b1;
          cnt_next      = '0;
          state_next    = ACCESS;
        end else begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end

      ACCESS: begin
        PSEL[slv_reg] = 1'b1;
        PENABLE       = 1'b1;
        if (PREADY_s[slv_reg]) begin
          if (!pwrite_reg) begin
            rdata_next = PRDATA_s[slv_reg];
          end
          state_next = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // This was the TIMEOUT-th ACCESS cycle without ready.
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RESP: begin
        if (!PRESET) begin
          rsp_valid[owner_reg] = 1'b1;
        end
        rsp_rdata  = rdata_reg;
        rsp_err    = err_reg;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign PADDR  = paddr_reg;
  assign PWRITE = pwrite_reg;
  assign PWDATA = pwdata_reg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
  import apb_master_arbiter_pkg::*;

  localparam int          N_REQ   = 2;
  localparam int          N_SLV   = 4;
  localparam int          TIMEOUT = 255;
  localparam logic [31:0] BASE    = 32'h1000_0000;

  logic                   PCLK = 1'b0;
  logic                   PRESET = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_write = '0;
  logic [N_REQ-1:0][31:0] req_addr = '0;
  logic [N_REQ-1:0][31:0] req_wdata = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic [31:0]            PWDATA;
  logic                   PENABLE;
  logic [N_SLV-1:0]       PSEL;
  logic [N_SLV-1:0][31:0] PRDATA_s;
  logic [N_SLV-1:0]       PREADY_s;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(
    .N_REQ(N_REQ), .N_SLV(N_SLV), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA_s(PRDATA_s), .PREADY_s(PREADY_s)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slaves: ready after slv_delay ACCESS cycles ----------
  int          slv_delay [N_SLV];
  logic [31:0] slv_data  [N_SLV];
  logic        noise = 1'b0;
  int          acc_cnt = 0;

  always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  always_comb begin
    PREADY_s = '0;
    PRDATA_s = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (PSEL[i]) begin
        PREADY_s[i] = PENABLE && (acc_cnt >= slv_delay[i]);
        PRDATA_s[i] = slv_data[i];
      end else if (noise) begin
        PREADY_s[i] = 1'b1;
        PRDATA_s[i] = 32'hBAD0_0000 | 32'(i);
      end
    end
  end

  // ---------------- requesters: hold each request until granted ----------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t             rq [N_REQ][$];
  logic [N_REQ-1:0] granted = '0;

  initial begin
    forever begin
      @(posedge PCLK);
      #1;
      for (int r = 0; r < N_REQ; r++) begin
        if (granted[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        if (rq[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_write[r] = rq[r][0].w;
          req_addr[r]  = rq[r][0].a;
          req_wdata[r] = rq[r][0].d;
        end else begin
          req_valid[r] = 1'b0;
          req_write[r] = 1'b0;
          req_addr[r]  = '0;
          req_wdata[r] = '0;
        end
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------
  // A transfer is described by its offset t from the grant cycle:
  // t=1 setup, t>=2 access, t=m_resp response. A miss responds at t=2.
  bit          m_busy = 0;
  int          m_t, m_resp, m_acc, m_owner, m_idx;
  bit          m_hit, m_err, m_w;
  logic [31:0] m_rdata, m_addr, m_wd;
  int          m_ptr = 0;

  int          ncyc = 0;
  int          grant_log[$];
  int          rsp_n = 0;
  int          last_grant_n, last_rsp_n;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [N_REQ-1:0] last_rv;
  logic [N_SLV-1:0] psel_seen, setup_psel;
  int          pen_cnt;
  logic        setup_pwrite;
  logic [31:0] setup_pwdata, acc_pwdata;

  initial begin
    logic [N_REQ-1:0] e_rdy, e_rv;
    logic [N_SLV-1:0] e_sel;
    logic [31:0]      e_rd;
    logic             e_err, e_en;
    bit               gnow;
    int               w, j;
    longint           a;
    @(posedge PCLK);
    forever begin
      @(negedge PCLK);
      ncyc++;
      e_rdy = '0; e_rv = '0; e_sel = '0; e_rd = '0; e_err = 1'b0; e_en = 1'b0;
      gnow = 0; w = 0;
      if (!m_busy) begin
        for (int k = 0; k < N_REQ; k++) begin
          j = (m_ptr + k) % N_REQ;
          if (!gnow && req_valid[j]) begin gnow = 1; w = j; end
        end
        if (PRESET) gnow = 0;
        if (gnow) e_rdy[w] = 1'b1;
      end else if (m_t == m_resp) begin
        if (!PRESET) e_rv[m_owner] = 1'b1;
        e_rd = m_rdata;
        e_err = m_err;
      end else if (m_hit) begin
        e_sel[m_idx] = 1'b1;
        e_en = (m_t >= 2);
      end

      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("psel", 32'(PSEL), 32'(e_sel));
      check("penable", 32'(PENABLE), 32'(e_en));
      if (e_rv != '0) begin
        check("rsp_rdata", rsp_rdata, e_rd);
        check("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (m_busy && m_hit && m_t >= 1) begin
        check("paddr", PADDR, m_addr);
        check("pwrite", 32'(PWRITE), 32'(m_w));
        check("pwdata", PWDATA, m_wd);
      end

      // observation log for the directed tests
      granted = req_ready;
      for (int r = 0; r < N_REQ; r++) if (req_ready[r]) begin
        grant_log.push_back(r);
        last_grant_n = ncyc;
      end
      if (rsp_valid != '0) begin
        rsp_n++;
        last_rsp_n = ncyc;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        last_rv    = rsp_valid;
        $display("txn: rsp_valid=%b rdata=%h err=%0d latency=%0d", rsp_valid, rsp_rdata, rsp_err,
                 last_rsp_n - last_grant_n);
      end
      psel_seen |= PSEL;
      if (PENABLE) begin
        pen_cnt++;
        acc_pwdata = PWDATA;
      end
      if (PSEL != '0 && !PENABLE) begin
        setup_psel   = PSEL;
        setup_pwrite = PWRITE;
        setup_pwdata = PWDATA;
      end

      // advance model across the coming edge
      if (PRESET) begin
        m_busy = 0; m_ptr = 0;
      end else if (gnow) begin
        m_busy = 1; m_t = 1; m_owner = w;
        m_addr = req_addr[w]; m_w = req_write[w]; m_wd = req_wdata[w];
        m_ptr = (w + 1) % N_REQ;
        a = longint'(m_addr);
        m_hit = (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(N_SLV) * 4096);
        m_idx = m_hit ? int'((a - longint'(BASE)) / 4096) : 0;
        m_resp = m_hit ? -1 : 2;
        m_acc = 0; m_rdata = '0; m_err = !m_hit;
      end else if (m_busy) begin
        if (m_t == m_resp) begin
          m_busy = 0;
        end else begin
          if (m_hit && m_t >= 2) begin
            m_acc++;
            if (PREADY_s[m_idx]) begin
              m_resp = m_t + 1;
              if (!m_w) m_rdata = PRDATA_s[m_idx];
            end else if (m_acc == TIMEOUT) begin
              m_resp = m_t + 1;
              m_err = 1;
            end
          end
          m_t++;
        end
      end
    end
  end

  // ---------------- directed stimulus ------------------------------------
  task automatic step();
    @(posedge PCLK);
    #2;
  endtask

  task automatic push(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_t t;
    t.w = w; t.a = a; t.d = d;
    rq[r].push_back(t);
  endtask

  task automatic do_reset(input int n);
    PRESET = 1'b1;
    repeat (n) step();
    PRESET = 1'b0;
    grant_log.delete();
  endtask

  // One request, waited on with a cycle bound; results land in last_*.
  task automatic run_one(input string name, input int r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    int base;
    base = rsp_n;
    psel_seen = '0; pen_cnt = 0; setup_psel = '0; setup_pwrite = 1'b0;
    setup_pwdata = '0; acc_pwdata = '0;
    push(r, w, a, d);
    for (int i = 0; i < 600 && rsp_n == base; i++) @(negedge PCLK);
    check({name, "_rsp_count"}, 32'(rsp_n - base), 32'd1);
    step();
  endtask

  logic [31:0] tbl_addr [4] = '{32'h1000_3FFC, 32'h1000_4000, 32'h0FFF_FFFC, 32'h1000_1FF0};
  logic        tbl_w    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic        tbl_err  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]  tbl_psel [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0010};

  initial begin
    int base;
    for (int i = 0; i < N_SLV; i++) begin
      slv_delay[i] = 0;
      slv_data[i]  = 32'h0000_1100 * 32'(i + 1);
    end

    // reset state
    repeat (3) step();
    @(negedge PCLK);
    check("reset_psel", 32'(PSEL), 32'd0);
    check("reset_penable", 32'(PENABLE), 32'd0);
    check("reset_paddr", PADDR, 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    PRESET = 1'b0;
    step();

    // single read, slave 0 ready one cycle after PENABLE
    slv_data[SLV_GPI] = 32'h0000_00A5;
    slv_delay[SLV_GPI] = 1;
    run_one("read0", 0, 1'b0, 32'h1000_0004, 32'h0);
    check("read0_latency", 32'(last_rsp_n - last_grant_n), 32'd4);
    check("read0_rdata", last_rdata, 32'h0000_00A5);
    check("read0_err", 32'(last_err), 32'd0);
    check("read0_owner", 32'(last_rv), 32'b01);
    check("read0_psel", 32'(psel_seen), 32'b0001);

    // write from requester 1 to slave 2
    run_one("write1", 1, 1'b1, 32'h1000_2000, 32'hDEAD_BEEF);
    check("write1_setup_psel", 32'(setup_psel), 32'b0100);
    check("write1_setup_pwrite", 32'(setup_pwrite), 32'd1);
    check("write1_setup_pwdata", setup_pwdata, 32'hDEAD_BEEF);
    check("write1_access_pwdata", acc_pwdata, 32'hDEAD_BEEF);
    check("write1_rdata", last_rdata, 32'd0);
    check("write1_owner", 32'(last_rv), 32'b10);
    check("write1_latency", 32'(last_rsp_n - last_grant_n), 32'd3);

    // both requesters busy from reset: grants alternate
    do_reset(2);
    step();
    base = rsp_n;
    push(0, 1'b0, 32'h1000_0010, 32'h0);
    push(0, 1'b0, 32'h1000_3020, 32'h0);
    push(1, 1'b1, 32'h1000_1030, 32'h1111_2222);
    push(1, 1'b1, 32'h1000_2040, 32'h3333_4444);
    for (int i = 0; i < 200 && rsp_n < base + 4; i++) @(negedge PCLK);
    check("rr_rsp_count", 32'(rsp_n - base), 32'd4);
    check("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    step();

    // decode miss: no PSEL, error two cycles after grant
    run_one("miss", 0, 1'b0, 32'h2000_0000, 32'h0);
    check("miss_latency", 32'(last_rsp_n - last_grant_n), 32'd2);
    check("miss_err", 32'(last_err), 32'd1);
    check("miss_rdata", last_rdata, 32'd0);
    check("miss_psel", 32'(psel_seen), 32'd0);

    // region boundaries, with unselected slaves shouting ready
    noise = 1'b1;
    slv_delay[SLV_TIMER] = 2;
    slv_delay[SLV_GPO] = 3;
    for (int i = 0; i < 4; i++) begin
      run_one($sformatf("bound%0d", i), i % 2, tbl_w[i], tbl_addr[i], 32'hC0DE_0000 | 32'(i));
      check($sformatf("bound%0d_err", i), 32'(last_err), 32'(tbl_err[i]));
      check($sformatf("bound%0d_psel", i), 32'(psel_seen), 32'(tbl_psel[i]));
    end
    noise = 1'b0;

    // slave never ready: timeout error
    slv_delay[SLV_GPO] = 100000;
    run_one("tmo", 0, 1'b0, 32'h1000_1000, 32'h0);
    check("tmo_penable_cycles", 32'(pen_cnt), 32'(TIMEOUT));
    check("tmo_err", 32'(last_err), 32'd1);
    check("tmo_rdata", last_rdata, 32'd0);
    check("tmo_latency", 32'(last_rsp_n - last_grant_n), 32'(TIMEOUT + 2));
    @(negedge PCLK);
    check("tmo_idle_psel", 32'(PSEL), 32'd0);
    step();

    // reset while in ACCESS: bus drops, aborted transfer never responds
    slv_delay[SLV_TIMER] = 100000;
    base = rsp_n;
    push(1, 1'b0, 32'h1000_3000, 32'h0);
    for (int i = 0; i < 20 && !PENABLE; i++) @(negedge PCLK);
    check("abort_reached_access", 32'(PENABLE), 32'd1);
    step();
    PRESET = 1'b1;
    step();
    @(negedge PCLK);
    check("abort_psel", 32'(PSEL), 32'd0);
    check("abort_penable", 32'(PENABLE), 32'd0);
    step();
    PRESET = 1'b0;
    repeat (4) step();
    check("abort_no_rsp", 32'(rsp_n - base), 32'd0);
    slv_delay[SLV_TIMER] = 0;
    grant_log.delete();
    run_one("after_reset", 0, 1'b0, 32'h1000_3008, 32'h0);
    check("after_reset_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 99), 32'd0);
    check("after_reset_rdata", last_rdata, slv_data[SLV_TIMER]);
    check("after_reset_err", 32'(last_err), 32'd0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
